mac_seq_ctrl: RTL
=================

Name: mac_seq_ctrl

Overview:
Job sequencer that drives the MAC datapath unit; it is the initiator side of that unit's operand/mux-select interface. The host loads up to 8 operand pairs into an internal buffer and pulses start. The block then issues one term every 2 cycles, to match the datapath's 2-cycle feedback latency, and captures the final accumulator value. Two job modes: sum-of-products (mode 0) and Horner polynomial evaluation (mode 1).

Parameters:
DEPTH, 8, operand buffer entries; max terms per job.
AW, 3, buffer address width, log2(DEPTH).

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  job request; sampled only in IDLE
mode  input  1  0 = sum-of-products, 1 = polynomial; latched at start
len_m1  input  AW  number of terms minus 1; latched at start
x_val  input  8  polynomial variable; latched at start
op_wr_en  input  1  buffer write strobe; ignored while busy
op_wr_addr  input  AW  buffer write index
op_wr_a  input  8  operand A (SOP multiplicand / polynomial coefficient)
op_wr_b  input  8  operand B (SOP multiplier; unused in mode 1)
mac_in_1  output  8  to datapath in_1
mac_in_2  output  8  to datapath in_2
mac_in_add  output  8  to datapath in_add
mac_mul_sel  output  1  to datapath mul_input_mux (1 = feedback)
mac_add_sel  output  1  to datapath adder_input_mux (1 = feedback)
mac_mode  output  1  to datapath mode; equals latched mode
mac_result_in  input  17  from datapath mac_output
busy  output  1  job in progress
done  output  1  one-cycle pulse when result updates
result  output  17  captured accumulator; holds until next done
result_valid  output  1  high from first done until next accepted start or reset

Behaviour:
- Reset (async): state IDLE. busy, done, result_valid = 0. result = 0. All mac_* outputs = 0. Buffer contents are don't-care.
- Buffer writes: on a clk edge with op_wr_en=1 and busy=0. A write on the same edge that start is accepted is visible to the job.
- States:
  - IDLE -> ISSUE on start=1. Latches mode, len_m1, x_val. Index k=0. Clears result_valid.
  - ISSUE -> WAIT.
  - WAIT -> ISSUE if k < len_m1 (k increments). WAIT -> CAPTURE if k = len_m1.
  - CAPTURE -> IDLE. result <= mac_result_in; done=1 and result_valid=1 in the following cycle.
- busy = 1 in ISSUE, WAIT and CAPTURE.
- Issue k, mode 0: in_1=A[k], in_2=B[k], in_add=0, mul_sel=0. add_sel=0 for k=0, 1 for k>0.
- Issue k, mode 1: mul_sel=0 and in_1=0 for k=0, else mul_sel=1. in_2=x, in_add=A[k], add_sel=0. A[0] is the highest-order coefficient.
- WAIT, CAPTURE and IDLE drive all mac_* data and select outputs to 0; mac_mode holds the latched value.
- Timing, with start accepted at edge 0 and n = len_m1+1:
  - issue k in cycle 2k+1
  - CAPTURE in cycle 2n+1 (mac_result_in valid there)
  - done high in cycle 2n+2
  - total 2n+2 cycles start-to-done
- The datapath's odd-phase accumulator values are never sampled.
- Back-to-back: a start in the done cycle is accepted.
- start while busy is ignored; it is not queued.
- Arithmetic: no saturation or masking. result equals the datapath's 17-bit wrapped value, including 16-bit product truncation in mode 1.
- Reset mid-job: immediate return to IDLE. No done pulse. result_valid=0, result=0.

Test Plan:
- SOP: A={1,2,3}, B={4,5,6}, len_m1=2, start at edge 0 -> done in cycle 8, result=32, busy high cycles 1-7.
- Poly: x=2, A={1,3,5}, len_m1=2, mode=1 -> result=15. Mux selects in issue cycles: mul_sel 0,1,1; add_sel 0,0,0.
- SOP wrap: A=B={255,255,255}, len_m1=2 -> result=64003 (0x0FA03).
- Single term: len_m1=0, A[0]=7, B[0]=9 -> done in cycle 4, result=63. Start in the done cycle with a new job -> accepted, busy high the next cycle.
- Protection: a start pulse and an op_wr_en to entry 0 while busy -> both ignored; the original job result is unchanged.
- Reset asserted in cycle 3 of an 8-term job -> all outputs 0 asynchronously, no done pulse. A following job completes correctly.

Source files
------------

// File: rtl/mac_seq_ctrl_if.sv
// mac_seq_ctrl_if
// Operand / mux-select link between the MAC job sequencer and the MAC
// datapath unit. The sequencer is the master (drives operands and selects),
// the datapath is the slave (returns its accumulator value).
//
// Signals:
//   mac_in_1      8   datapath in_1
//   mac_in_2      8   datapath in_2
//   mac_in_add    8   datapath in_add
//   mac_mul_sel   1   datapath mul_input_mux (1 = feedback)
//   mac_add_sel   1   datapath adder_input_mux (1 = feedback)
//   mac_mode      1   datapath mode
//   mac_result_in 17  datapath mac_output (accumulator)
interface mac_seq_ctrl_if;
    logic [7:0]  mac_in_1;
    logic [7:0]  mac_in_2;
    logic [7:0]  mac_in_add;
    logic        mac_mul_sel;
    logic        mac_add_sel;
    logic        mac_mode;
    logic [16:0] mac_result_in;

    modport master (
        output mac_in_1,
        output mac_in_2,
        output mac_in_add,
        output mac_mul_sel,
        output mac_add_sel,
        output mac_mode,
        input  mac_result_in
    );

    modport slave (
        input  mac_in_1,
        input  mac_in_2,
        input  mac_in_add,
        input  mac_mul_sel,
        input  mac_add_sel,
        input  mac_mode,
        output mac_result_in
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl
// Job sequencer for the MAC datapath. The host fills an operand buffer of
// DEPTH (A,B) pairs, then pulses start. One term is issued every 2 cycles to
// match the datapath's 2-cycle feedback latency; after the last term the
// accumulator is captured into result and done pulses for one cycle.
// Mode 0 = sum of products, mode 1 = Horner polynomial evaluation.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   start                job request (sampled only when idle)
//   mode, len_m1, x_val  job parameters, latched when start is accepted
//   op_wr_en/addr/a/b    operand buffer write port (ignored while busy)
//   mac                  master side of the datapath link (mac_seq_ctrl_if)
//   busy                 job in progress
//   done                 one-cycle pulse when result updates
//   result               captured accumulator, held until next done
//   result_valid         set by done, cleared by next accepted start
module mac_seq_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            mode,
    input  logic [AW-1:0]   len_m1,
    input  logic [7:0]      x_val,
    input  logic            op_wr_en,
    input  logic [AW-1:0]   op_wr_addr,
    input  logic [7:0]      op_wr_a,
    input  logic [7:0]      op_wr_b,
    mac_seq_ctrl_if.master  mac,
    output logic            busy,
    output logic            done,
    output logic [16:0]     result,
    output logic            result_valid
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_n;
    logic [AW-1:0] k_r;
    logic [AW-1:0] k_n;
    logic [AW-1:0] len_r;
    logic [7:0]    x_r;
    logic          mode_r;

    logic [7:0]    buf_a_r [DEPTH];
    logic [7:0]    buf_b_r [DEPTH];

    logic          busy_r;
    logic          done_r;
    logic [16:0]   result_r;
    logic          valid_r;

    logic [7:0]    in_1_r;
    logic [7:0]    in_2_r;
    logic [7:0]    in_add_r;
    logic          mul_sel_r;
    logic          add_sel_r;

    logic [7:0]    in_1_n;
    logic [7:0]    in_2_n;
    logic [7:0]    in_add_n;
    logic          mul_sel_n;
    logic          add_sel_n;

    logic          wr_ok_s;
    logic          job_mode_s;
    logic [7:0]    job_x_s;
    logic [7:0]    rd_a_s;
    logic [7:0]    rd_b_s;

    assign wr_ok_s = op_wr_en && !busy_r;

    // Operand buffer write port; frozen for the whole job.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            buf_a_r[op_wr_addr] <= op_wr_a;
            buf_b_r[op_wr_addr] <= op_wr_b;
        end
    end

    // Next-state, term index and next datapath drive values.
    always_comb begin
        state_n   = state_r;
        k_n       = k_r;
        in_1_n    = 8'd0;
        in_2_n    = 8'd0;
        in_add_n  = 8'd0;
        mul_sel_n = 1'b0;
        add_sel_n = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_ISSUE;
                    k_n     = {AW{1'b0}};
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (k_r == len_r) begin
                    state_n = ST_CAPTURE;
                end else begin
                    state_n = ST_ISSUE;
                    k_n     = k_r + AW'(1);
                end
            end
            ST_CAPTURE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // The datapath drive is registered, so it is computed for the state
        // being entered. On the start edge the job parameters are not latched
        // yet, so they come straight from the ports.
        if (state_r == ST_IDLE) begin
            job_mode_s = mode;
            job_x_s    = x_val;
        end else begin
            job_mode_s = mode_r;
            job_x_s    = x_r;
        end

        // A buffer write on the start edge must reach term 0 of that job.
        if (wr_ok_s && (op_wr_addr == k_n)) begin
            rd_a_s = op_wr_a;
            rd_b_s = op_wr_b;
        end else begin
            rd_a_s = buf_a_r[k_n];
            rd_b_s = buf_b_r[k_n];
        end

        if (state_n == ST_ISSUE) begin
            if (job_mode_s == 1'b0) begin
                // Sum of products: first term seeds the accumulator.
                in_1_n    = rd_a_s;
                in_2_n    = rd_b_s;
                add_sel_n = (k_n != {AW{1'b0}});
            end else begin
                // Horner: acc = acc * x + A[k]; first term multiplies zero.
                in_2_n    = job_x_s;
                in_add_n  = rd_a_s;
                mul_sel_n = (k_n != {AW{1'b0}});
            end
        end else begin
            in_1_n    = 8'd0;
            in_2_n    = 8'd0;
            in_add_n  = 8'd0;
            mul_sel_n = 1'b0;
            add_sel_n = 1'b0;
        end
    end

    // State, job parameters, datapath drive and host-facing status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            k_r       <= {AW{1'b0}};
            len_r     <= {AW{1'b0}};
            x_r       <= 8'd0;
            mode_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            result_r  <= 17'd0;
            valid_r   <= 1'b0;
            in_1_r    <= 8'd0;
            in_2_r    <= 8'd0;
            in_add_r  <= 8'd0;
            mul_sel_r <= 1'b0;
            add_sel_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            k_r       <= k_n;
            busy_r    <= (state_n != ST_IDLE);
            done_r    <= (state_r == ST_CAPTURE);
            in_1_r    <= in_1_n;
            in_2_r    <= in_2_n;
            in_add_r  <= in_add_n;
            mul_sel_r <= mul_sel_n;
            add_sel_r <= add_sel_n;
            if ((state_r == ST_IDLE) && start) begin
                mode_r  <= mode;
                len_r   <= len_m1;
                x_r     <= x_val;
                valid_r <= 1'b0;
            end
            if (state_r == ST_CAPTURE) begin
                result_r <= mac.mac_result_in;
                valid_r  <= 1'b1;
            end
        end
    end

    assign mac.mac_in_1    = in_1_r;
    assign mac.mac_in_2    = in_2_r;
    assign mac.mac_in_add  = in_add_r;
    assign mac.mac_mul_sel = mul_sel_r;
    assign mac.mac_add_sel = add_sel_r;
    assign mac.mac_mode    = mode_r;

    assign busy         = busy_r;
    assign done         = done_r;
    assign result       = result_r;
    assign result_valid = valid_r;

endmodule
